// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the bus router.
// Holds the router state encoding, the m_sel access-size encodings and the default error read data.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, DECODE_ERR, WAIT, DONE} state_t;
  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational priority address decoder.
// Ports: addr (in)     address to decode.
//        base (in)     flat per-slave base addresses.
//        mask (in)     flat per-slave masks.
//        hit (out)     some slave matches.
//        idx (out)     lowest matching slave index.
module bus_addr_decode #(
  parameter int N_SLAVES = 5,
  parameter int AW = 32,
  parameter int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [AW-1:0]          addr,
  input  logic [N_SLAVES*AW-1:0] base,
  input  logic [N_SLAVES*AW-1:0] mask,
  output logic                   hit,
  output logic [IW-1:0]          idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if ((addr & mask[i*AW +: AW]) == base[i*AW +: AW]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/bus_router.sv
// bus_router: single-master, N-slave bus router with timeout and error response.
// Ports: clk, rstn (async active-low reset).
//        m_* master side: level rd/we request in, ack/err pulse and read data out.
//        s_* slave side: per-slave flat addr/data/sel/rd/we out, read data and ack in.
//        err_addr_o address of the last failed transaction, err_irq_o one pulse per error.
module bus_router
  import bus_pkg::*;
#(
  parameter int N_SLAVES = 5,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AW-1:0]          m_addr_i,
  input  logic [DW-1:0]          m_data_i,
  input  logic [1:0]             m_sel_i,
  input  logic                   m_rd_i,
  input  logic                   m_we_i,
  output logic [DW-1:0]          m_data_o,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic [N_SLAVES*AW-1:0] s_addr_o,
  output logic [N_SLAVES*DW-1:0] s_data_o,
  output logic [N_SLAVES*2-1:0]  s_sel_o,
  output logic [N_SLAVES-1:0]    s_rd_o,
  output logic [N_SLAVES-1:0]    s_we_o,
  input  logic [N_SLAVES*DW-1:0] s_data_i,
  input  logic [N_SLAVES-1:0]    s_ack_i,
  output logic [AW-1:0]          err_addr_o,
  output logic                   err_irq_o
);
  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [1:0] sel_q;
  logic rd_q, we_q;
  logic [IW-1:0] idx_q, idx;
  logic [TW-1:0] cnt;
  logic hit, req, ack_sel, go_ok, go_err;
  assign req = m_rd_i | m_we_i;
  assign ack_sel = s_ack_i[idx_q];
  bus_addr_decode #(.N_SLAVES(N_SLAVES), .AW(AW), .IW(IW)) u_dec (
    .addr(m_addr_i),
    .base(SLAVE_BASE),
    .mask(SLAVE_MASK),
    .hit (hit),
    .idx (idx)
  );
  // An ack in the same cycle the counter hits zero wins over the timeout.
  always_comb begin
    state_nxt = state;
    go_ok = 1'b0;
    go_err = 1'b0;
    case (state)
      IDLE: state_nxt = req ? (hit ? WAIT : DECODE_ERR) : IDLE;
      WAIT: begin
        go_ok = ack_sel;
        go_err = !ack_sel && cnt == '0;
        state_nxt = (go_ok || go_err) ? DONE : WAIT;
      end
      DECODE_ERR: begin
        go_err = 1'b1;
        state_nxt = DONE;
      end
      DONE: state_nxt = req ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr_q <= '0;
      data_q <= '0;
      sel_q <= '0;
      rd_q <= 1'b0;
      we_q <= 1'b0;
      idx_q <= '0;
      cnt <= '0;
      m_data_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      err_addr_o <= '0;
      err_irq_o <= 1'b0;
    end else begin
      m_ack_o <= go_ok || go_err;
      m_err_o <= go_err;
      err_irq_o <= go_err;
      if (state == IDLE && req) begin
        addr_q <= m_addr_i;
        data_q <= m_data_i;
        sel_q <= m_sel_i;
        we_q <= m_we_i;
        rd_q <= !m_we_i;
        idx_q <= idx;
        cnt <= TW'(TIMEOUT);
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (go_ok) m_data_o <= s_data_i[idx_q*DW +: DW];
      if (go_err) begin
        m_data_o <= ERR_DATA;
        err_addr_o <= addr_q;
      end
    end
  // Slave ports are driven from registered state only, so they drop with the state change.
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_s
    logic on;
    assign on = state == WAIT && idx_q == IW'(i);
    assign s_addr_o[i*AW +: AW] = on ? addr_q : '0;
    assign s_data_o[i*DW +: DW] = on ? data_q : '0;
    assign s_sel_o[i*2 +: 2] = on ? sel_q : 2'b00;
    assign s_rd_o[i] = on && rd_q;
    assign s_we_o[i] = on && we_q;
  end
endmodule

// File: tb/tb_bus_router.sv
// tb_bus_router: directed bench with a transaction-level model of bus_router.
module tb_bus_router;
  import bus_pkg::*;
  localparam int N = 5;
  localparam int TMO = 8;
  localparam logic [31:0] EDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] BA [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h4000_0000};
  localparam logic [31:0] MA [N] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};
  localparam logic [N*32-1:0] BASE = {BA[4], BA[3], BA[2], BA[1], BA[0]};
  localparam logic [N*32-1:0] MASK = {MA[4], MA[3], MA[2], MA[1], MA[0]};
  logic clk = 1'b0, rstn;
  logic [31:0] m_addr_i, m_data_i, m_data_o, err_addr_o;
  logic [1:0] m_sel_i;
  logic m_rd_i, m_we_i, m_ack_o, m_err_o, err_irq_o;
  logic [N*32-1:0] s_addr_o, s_data_o, s_data_i;
  logic [N*2-1:0] s_sel_o;
  logic [N-1:0] s_rd_o, s_we_o, s_ack_i, force_ack;
  int checks = 0, errors = 0, cyc = 0;
  int dly [N] = '{0, 1, 2, 0, -1};
  logic [31:0] rdata [N] = '{32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  int hi_cnt [N];
  logic x_valid = 1'b0, x_err = 1'b0, x_we = 1'b0;
  int t0 = 0, x_tgt = -1, x_ack_cyc = 0;
  logic [31:0] x_addr, x_wdata, err_addr_m = '0;
  logic [1:0] x_sel;
  bus_router #(.N_SLAVES(N), .AW(32), .DW(32), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
               .TIMEOUT(TMO), .ERR_DATA(EDATA)) dut (
    .clk(clk), .rstn(rstn), .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
    .m_rd_i(m_rd_i), .m_we_i(m_we_i), .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_rd_o(s_rd_o), .s_we_o(s_we_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .err_addr_o(err_addr_o), .err_irq_o(err_irq_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int i = 0; i < N; i++) hi_cnt[i] <= (s_rd_o[i] || s_we_o[i]) ? hi_cnt[i] + 1 : 0;
  // Slave i acks dly[i] cycles after its strobe rises; force_ack injects stray acks.
  always_comb begin
    s_ack_i = force_ack;
    s_data_i = '0;
    for (int i = 0; i < N; i++) begin
      if ((s_rd_o[i] || s_we_o[i]) && hi_cnt[i] == dly[i]) s_ack_i[i] = 1'b1;
      s_data_i[i*32 +: 32] = rdata[i];
    end
  end
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) if ((a & MA[i]) == BA[i]) return i;
    return -1;
  endfunction
  // Model: a transaction started at cycle t0 strobes its target on cycles 1..ack-1 and acks at x_ack_cyc.
  always @(negedge clk) begin
    logic [N*32-1:0] ea, ed;
    logic [N*2-1:0] es;
    logic [N-1:0] erd, ewe;
    logic stb, ack;
    int rel;
    ea = '0; ed = '0; es = '0; erd = '0; ewe = '0;
    rel = cyc - t0;
    stb = rstn && x_valid && x_tgt >= 0 && rel >= 1 && rel < x_ack_cyc;
    ack = rstn && x_valid && rel == x_ack_cyc;
    if (stb) begin
      ea[x_tgt*32 +: 32] = x_addr;
      ed[x_tgt*32 +: 32] = x_wdata;
      es[x_tgt*2 +: 2] = x_sel;
      erd[x_tgt] = !x_we;
      ewe[x_tgt] = x_we;
    end
    chk("m_ack_o", m_ack_o, ack);
    chk("m_err_o", m_err_o, ack && x_err);
    chk("err_irq_o", err_irq_o, ack && x_err);
    chk("s_rd_o", s_rd_o, erd);
    chk("s_we_o", s_we_o, ewe);
    chk("s_addr_o", s_addr_o, ea);
    chk("s_data_o", s_data_o, ed);
    chk("s_sel_o", s_sel_o, es);
    chk("err_addr_o", err_addr_o, !rstn ? 32'h0 : (x_valid && x_err && rel >= x_ack_cyc) ? x_addr : err_addr_m);
    if (!rstn) chk("m_data_o_rst", m_data_o, 0);
    else if (ack && (x_err || !x_we)) chk("m_data_o", m_data_o, x_err ? EDATA : rdata[x_tgt]);
  end
  task automatic start(input logic [31:0] a, input logic rd, input logic we, input logic [31:0] wd, input logic [1:0] sz);
    @(posedge clk); #1;
    if (x_valid && x_err) err_addr_m = x_addr;
    x_tgt = decode(a);
    x_addr = a; x_wdata = wd; x_sel = sz; x_we = we;
    if (x_tgt < 0) begin x_ack_cyc = 2; x_err = 1'b1; end
    else if (dly[x_tgt] >= 0 && dly[x_tgt] <= TMO) begin x_ack_cyc = dly[x_tgt] + 2; x_err = 1'b0; end
    else begin x_ack_cyc = TMO + 2; x_err = 1'b1; end
    t0 = cyc;
    x_valid = 1'b1;
    m_addr_i = a; m_data_i = wd; m_sel_i = sz; m_rd_i = rd; m_we_i = we;
  endtask
  task automatic at_cyc(input int r);
    do @(negedge clk); while (cyc - t0 < r);
  endtask
  task automatic finish_txn(input int hold);
    at_cyc(x_ack_cyc + 1 + hold);
    m_rd_i = 1'b0; m_we_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    rstn = 1'b0; force_ack = '0;
    m_addr_i = '0; m_data_i = '0; m_sel_i = '0; m_rd_i = 1'b0; m_we_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err_addr", err_addr_o, 0);
    chk("rst_s_rd", s_rd_o, 0);
    rstn = 1'b1;
    // write hit on slave 2, stray ack from slave 4 ignored
    start(32'h2000_0010, 1'b0, 1'b1, 32'h1234_5678, SEL_WORD);
    at_cyc(1);
    chk("wr_s_we", s_we_o, 5'b00100);
    chk("wr_s_rd", s_rd_o, 5'b00000);
    chk("wr_addr2", s_addr_o[2*32 +: 32], 32'h2000_0010);
    chk("wr_data2", s_data_o[2*32 +: 32], 32'h1234_5678);
    force_ack = 5'b10000;
    at_cyc(2);
    force_ack = '0;
    at_cyc(4);
    chk("wr_ack", m_ack_o, 1);
    chk("wr_err", m_err_o, 0);
    finish_txn(0);
    // read hit on slave 0, combinational ack at cycle 1
    start(32'h0000_0004, 1'b1, 1'b0, 32'h0, SEL_HALF);
    at_cyc(2);
    chk("rd_ack", m_ack_o, 1);
    chk("rd_data", m_data_o, 32'hCAFE_F00D);
    finish_txn(0);
    // unmapped read
    start(32'hF000_0000, 1'b1, 1'b0, 32'h0, SEL_BYTE);
    at_cyc(1);
    chk("um_s_rd", s_rd_o, 0);
    at_cyc(2);
    chk("um_ack", m_ack_o, 1);
    chk("um_err", m_err_o, 1);
    chk("um_data", m_data_o, 32'hDEAD_BEEF);
    chk("um_err_addr", err_addr_o, 32'hF000_0000);
    chk("um_irq", err_irq_o, 1);
    at_cyc(3);
    chk("um_irq_pulse", err_irq_o, 0);
    finish_txn(0);
    // timeout on slave 4, late ack at cycle 12 discarded
    start(32'h4000_0008, 1'b1, 1'b0, 32'h0, SEL_WORD);
    at_cyc(9);
    chk("to_s_rd9", s_rd_o, 5'b10000);
    at_cyc(10);
    chk("to_s_rd10", s_rd_o, 0);
    chk("to_ack", m_ack_o, 1);
    chk("to_err", m_err_o, 1);
    chk("to_err_addr", err_addr_o, 32'h4000_0008);
    at_cyc(12);
    force_ack = 5'b10000;
    at_cyc(13);
    force_ack = '0;
    chk("to_late_ack", m_ack_o, 0);
    finish_txn(0);
    // ack in the cycle the counter reaches zero succeeds; rd+we together is a write
    dly[2] = TMO;
    start(32'h2000_0100, 1'b1, 1'b1, 32'hA5A5_0001, SEL_WORD);
    at_cyc(9);
    chk("b8_s_we", s_we_o, 5'b00100);
    chk("b8_s_rd", s_rd_o, 0);
    at_cyc(10);
    chk("b8_ack", m_ack_o, 1);
    chk("b8_err", m_err_o, 0);
    finish_txn(0);
    // one cycle too late is a timeout
    dly[2] = TMO + 1;
    start(32'h2000_0200, 1'b1, 1'b0, 32'h0, SEL_WORD);
    at_cyc(10);
    chk("b9_err", m_err_o, 1);
    chk("b9_err_addr", err_addr_o, 32'h2000_0200);
    finish_txn(0);
    dly[2] = 2;
    // overlap: slaves 1 and 3 both match, request held 5 cycles past the ack
    start(32'h1000_0040, 1'b1, 1'b0, 32'h0, SEL_WORD);
    at_cyc(1);
    chk("ov_s_rd", s_rd_o, 5'b00010);
    at_cyc(3);
    chk("ov_data", m_data_o, 32'h1111_1111);
    at_cyc(8);
    chk("ov_no_replay", s_rd_o, 0);
    finish_txn(5);
    // reset while slave 2 is strobed
    start(32'h2000_0020, 1'b1, 1'b0, 32'h0, SEL_WORD);
    at_cyc(1);
    chk("rw_s_rd", s_rd_o, 5'b00100);
    #1 rstn = 1'b0;
    #1;
    chk("rw_s_rd0", s_rd_o, 0);
    chk("rw_s_addr0", s_addr_o, 0);
    chk("rw_ack0", m_ack_o, 0);
    chk("rw_err_addr0", err_addr_o, 0);
    chk("rw_data0", m_data_o, 0);
    m_rd_i = 1'b0;
    x_valid = 1'b0;
    err_addr_m = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    start(32'h0000_0008, 1'b1, 1'b0, 32'h0, SEL_WORD);
    at_cyc(2);
    chk("rw_after_ack", m_ack_o, 1);
    chk("rw_after_data", m_data_o, 32'hCAFE_F00D);
    finish_txn(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
